// File: rtl/rf_wb_arbiter_if.sv
// Bundle of RegisterFile write-back arbitration signals: two producer requests,
// the registered write-back port, and the decode-side pending-write query.
interface rf_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [REG_W-1:0]  req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [REG_W-1:0]  req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              write_back_en;
  logic [REG_W-1:0]  write_back_reg;
  logic [DATA_W-1:0] write_back;
  logic              issue_en;
  logic [REG_W-1:0]  issue_reg;
  logic [REG_W-1:0]  a_reg;
  logic [REG_W-1:0]  b_reg;
  logic              a_busy;
  logic              b_busy;
  logic              stall;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    output issue_en, issue_reg, a_reg, b_reg,
    input  req0_ready, req1_ready,
    input  write_back_en, write_back_reg, write_back,
    input  a_busy, b_busy, stall
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    input  issue_en, issue_reg, a_reg, b_reg,
    output req0_ready, req1_ready,
    output write_back_en, write_back_reg, write_back,
    output a_busy, b_busy, stall
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RegisterFile write-back port between ALU (req0) and
// load/multi-cycle (req1) producers, and tracks pending writes for RAW stalls.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NREG  = 1 << REG_W;

  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_wb_en;
  logic [REG_W-1:0]  r_wb_reg;
  logic [DATA_W-1:0] r_wb_data;
  logic [NREG-1:0]   r_busy;

  logic              w_starve;
  logic              w_req0_ready;
  logic              w_req1_ready;
  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_xfer;
  logic [REG_W-1:0]  w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic [NREG-1:0]   w_busy_nxt;

  // Readies are mutually exclusive whenever both producers are valid.
  assign w_starve     = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_req0_ready = ~w_starve | ~bus.req1_valid;
  assign w_req1_ready = ~bus.req0_valid | w_starve;
  assign w_xfer0      = bus.req0_valid & w_req0_ready;
  assign w_xfer1      = bus.req1_valid & w_req1_ready;
  assign w_xfer       = w_xfer0 | w_xfer1;

  always_comb begin
    w_sel_reg  = bus.req0_reg;
    w_sel_data = bus.req0_data;
    if (w_xfer1) begin
      w_sel_reg  = bus.req1_reg;
      w_sel_data = bus.req1_data;
    end
  end

  // Clear is applied before set so a same-edge re-issue keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wb_en) begin
      w_busy_nxt[r_wb_reg] = 1'b0;
    end
    if (bus.issue_en && (bus.issue_reg != '0)) begin
      w_busy_nxt[bus.issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_wb_en      <= 1'b0;
      r_wb_reg     <= '0;
      r_wb_data    <= '0;
      r_busy       <= '0;
    end else begin
      if (!bus.req1_valid || w_xfer1) begin
        r_starve_cnt <= '0;
      end else if (!w_starve) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
      r_wb_en <= w_xfer & (w_sel_reg != '0);
      if (w_xfer) begin
        r_wb_reg  <= w_sel_reg;
        r_wb_data <= w_sel_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.req0_ready     = w_req0_ready;
  assign bus.req1_ready     = w_req1_ready;
  assign bus.write_back_en  = r_wb_en;
  assign bus.write_back_reg = r_wb_reg;
  assign bus.write_back     = r_wb_data;
  assign bus.a_busy         = r_busy[bus.a_reg];
  assign bus.b_busy         = r_busy[bus.b_reg];
  assign bus.stall          = r_busy[bus.a_reg] | r_busy[bus.b_reg];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter; write-back expectations go through a queue.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_wb_arbiter_if #(.DATA_W(32), .REG_W(5)) bus ();

  rf_wb_arbiter #(.DATA_W(32), .REG_W(5), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic        iss;
    logic [4:0]  ireg;
    logic [4:0]  a;
    logic [4:0]  b;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_abusy;
    logic        e_bbusy;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  rg;
    logic [31:0] d;
  } wb_t;

  vec_t vecs[$];
  wb_t  exp_q[$];

  function automatic vec_t mk(input logic rs, input logic v0, input logic [4:0] r0,
                              input logic [31:0] d0, input logic v1, input logic [4:0] r1,
                              input logic [31:0] d1, input logic iss, input logic [4:0] ireg,
                              input logic [4:0] a, input logic [4:0] b, input logic e0,
                              input logic e1, input logic ea, input logic eb);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
    v.iss = iss; v.ireg = ireg; v.a = a; v.b = b;
    v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_abusy = ea; v.e_bbusy = eb;
    return v;
  endfunction

  function automatic vec_t idle(input logic [4:0] a, input logic [4:0] b,
                                input logic ea, input logic eb);
    return mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, a, b, 1'b1, 1'b1, ea, eb);
  endfunction

  // Both producers valid (r1 from ALU, r2 from load), per-cycle distinct data.
  function automatic vec_t both(input logic rs, input int k, input logic e0, input logic e1);
    return mk(rs, 1'b1, 5'd1, 32'hA000_0000 + 32'(k), 1'b1, 5'd2, 32'hB000_0000 + 32'(k),
              1'b0, 5'd0, 5'd0, 5'd0, e0, e1, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    wb_t e;
    wb_t g;
    rst            = v.rst;
    bus.req0_valid = v.v0;
    bus.req0_reg   = v.r0;
    bus.req0_data  = v.d0;
    bus.req1_valid = v.v1;
    bus.req1_reg   = v.r1;
    bus.req1_data  = v.d1;
    bus.issue_en   = v.iss;
    bus.issue_reg  = v.ireg;
    bus.a_reg      = v.a;
    bus.b_reg      = v.b;
    #2;
    chk("req0_ready", idx, 32'(bus.req0_ready), 32'(v.e_rdy0));
    chk("req1_ready", idx, 32'(bus.req1_ready), 32'(v.e_rdy1));
    chk("a_busy", idx, 32'(bus.a_busy), 32'(v.e_abusy));
    chk("b_busy", idx, 32'(bus.b_busy), 32'(v.e_bbusy));
    chk("stall", idx, 32'(bus.stall), 32'(v.e_abusy | v.e_bbusy));
    e.en = 1'b0; e.rg = '0; e.d = '0;
    if (!v.rst) begin
      if (v.v0 && v.e_rdy0) begin
        e.en = (v.r0 != 5'd0); e.rg = v.r0; e.d = v.d0;
      end else if (v.v1 && v.e_rdy1) begin
        e.en = (v.r1 != 5'd0); e.rg = v.r1; e.d = v.d1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL wb_queue step %0d: got empty expected entry", idx);
    end else begin
      g = exp_q.pop_front();
      chk("write_back_en", idx, 32'(bus.write_back_en), 32'(g.en));
      if (g.en) begin
        chk("write_back_reg", idx, 32'(bus.write_back_reg), 32'(g.rg));
        chk("write_back", idx, bus.write_back, g.d);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
    bus.issue_en = 1'b0; bus.issue_reg = '0; bus.a_reg = 5'd3; bus.b_reg = 5'd7;
    @(posedge clk);
    #1;
    chk("reset_wb_en", 0, 32'(bus.write_back_en), 32'h0);
    chk("reset_wb_reg", 0, 32'(bus.write_back_reg), 32'h0);
    chk("reset_wb_data", 0, bus.write_back, 32'h0);
    chk("reset_a_busy", 0, 32'(bus.a_busy), 32'h0);
    chk("reset_b_busy", 0, 32'(bus.b_busy), 32'h0);

    // Reset held with both producers requesting, then a single ALU write.
    vecs.push_back(both(1'b1, 0, 1'b1, 1'b0));
    vecs.push_back(both(1'b1, 1, 1'b1, 1'b0));
    vecs.push_back(idle(5'd0, 5'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                      5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(idle(5'd0, 5'd0, 1'b0, 1'b0));
    // Continuous contention: ALU wins four cycles, load wins the fifth.
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < 5; k++)
        vecs.push_back(both(1'b0, rep * 5 + k, k < 4, k == 4));
    vecs.push_back(idle(5'd0, 5'd0, 1'b0, 1'b0));
    // Write to r0 is accepted but never strobes the register file.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0,
                      5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(idle(5'd0, 5'd0, 1'b0, 1'b0));
    // Scoreboard: issue r7, write it back, busy drops the cycle after the strobe.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                      5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(idle(5'd7, 5'd0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0,
                      5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(5'd7, 5'd0, 1'b1, 1'b0));
    vecs.push_back(idle(5'd7, 5'd7, 1'b0, 1'b0));
    // Re-issue r7 on the same edge its write-back retires.
    vecs.push_back(mk(1'b0, 1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                      5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                      5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(5'd7, 5'd7, 1'b1, 1'b1));
    // Issuing r0 never marks it busy.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                      5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(idle(5'd0, 5'd7, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 5'd7, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                      5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(idle(5'd0, 5'd7, 1'b0, 1'b1));
    vecs.push_back(idle(5'd0, 5'd7, 1'b0, 1'b0));
    // Reset mid-operation drops the transfer and clears the scoreboard.
    vecs.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3,
                      5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                      5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(idle(5'd3, 5'd0, 1'b0, 1'b0));
    // Reset restarts the starvation count.
    for (int k = 0; k < 3; k++) vecs.push_back(both(1'b0, 20 + k, 1'b1, 1'b0));
    vecs.push_back(both(1'b1, 23, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++) vecs.push_back(both(1'b0, 24 + k, 1'b1, 1'b0));
    vecs.push_back(both(1'b0, 28, 1'b0, 1'b1));
    // A cycle with req1 idle also restarts the count.
    vecs.push_back(both(1'b0, 30, 1'b1, 1'b0));
    vecs.push_back(both(1'b0, 31, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 5'd1, 32'hC0, 1'b0, 5'd2, 32'hC1, 1'b0, 5'd0,
                      5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) vecs.push_back(both(1'b0, 32 + k, 1'b1, 1'b0));
    vecs.push_back(both(1'b0, 36, 1'b0, 1'b1));

    foreach (vecs[i]) apply(vecs[i], i);

    // Long contention run: the 1-in-5 load grant pattern keeps repeating.
    for (int k = 0; k < 15; k++)
      apply(both(1'b0, 100 + k, (k % 5) != 4, (k % 5) == 4), 1000 + k);
    apply(idle(5'd0, 5'd0, 1'b0, 1'b0), 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
